sysmul_digit_feeder: RTL and testbench

Transmit end of the digit-serial interface into the GF(2^163) systolic multiplier array (D=16 digits).
- Accepts one full operand set (A, B and reduction polynomial G) over a valid/ready handshake.
- Serializes each operand into 11 16-bit digits, MSB digit first, and drives them into the first PE of the chain.
- Drives the ctr marker with the first digit of each operation.
- After the last digit, drives zero digits for a programmable drain period, then pulses done and accepts the next operand set.

---
 rtl/sysmul_digit_feeder_if.sv | 30 +++
 rtl/sysmul_digit_feeder.sv | 135 +++++++++++++
 tb/tb_sysmul_digit_feeder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sysmul_digit_feeder_if.sv
// Operand-load handshake and digit-serial output bundle for the systolic multiplier feeder.
interface sysmul_digit_feeder_if #(
    parameter int unsigned M = 163,
    parameter int unsigned D = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] a_in;
    logic [M-1:0] b_in;
    logic [M-1:0] g_in;
    logic [D-1:0] a_out;
    logic [D-1:0] b_out;
    logic [D-1:0] g_out;
    logic         ctr_out;
    logic         dig_valid;
    logic         busy;
    logic         done;

    // Feeder side.
    modport slave (
        input  in_valid, a_in, b_in, g_in,
        output in_ready, a_out, b_out, g_out, ctr_out, dig_valid, busy, done
    );

    // Operand source / PE-chain side.
    modport master (
        output in_valid, a_in, b_in, g_in,
        input  in_ready, a_out, b_out, g_out, ctr_out, dig_valid, busy, done
    );
endinterface

// File: rtl/sysmul_digit_feeder.sv
// Digit-serial transmit end of the GF(2^M) systolic multiplier: accepts one operand set,
// streams NDIG digits MSB-first per operand, then drains FLUSH zero cycles and pulses done.
module sysmul_digit_feeder #(
    parameter int unsigned M     = 163,
    parameter int unsigned D     = 16,
    parameter int unsigned FLUSH = 22
) (
    input logic                     clk,
    input logic                     rstn,
    sysmul_digit_feeder_if.slave    bus
);
    localparam int unsigned NDIG = (M + D - 1) / D;
    localparam int unsigned W    = NDIG * D;

    typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_sr_q, a_sr_d, b_sr_q, b_sr_d, g_sr_q, g_sr_d;
    logic [D-1:0]   a_out_q, a_out_d, b_out_q, b_out_d, g_out_q, g_out_d;
    logic           ctr_q, ctr_d, dv_q, dv_d, busy_q, busy_d, done_q, done_d;
    logic [3:0]     dig_cnt_q, dig_cnt_d;
    logic [7:0]     drain_q, drain_d;
    logic [W-1:0]   a_pad, b_pad, g_pad;

    // Zero-extend to a whole number of digits so digit 0 carries the top bits.
    assign a_pad = W'(bus.a_in);
    assign b_pad = W'(bus.b_in);
    assign g_pad = W'(bus.g_in);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        g_sr_d    = g_sr_q;
        dig_cnt_d = dig_cnt_q;
        drain_d   = drain_q;
        a_out_d   = '0;
        b_out_d   = '0;
        g_out_d   = '0;
        ctr_d     = 1'b0;
        dv_d      = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    // Digit 0 goes straight to the output flops; the rest wait in the shifters.
                    a_out_d   = a_pad[W-1 -: D];
                    b_out_d   = b_pad[W-1 -: D];
                    g_out_d   = g_pad[W-1 -: D];
                    a_sr_d    = a_pad << D;
                    b_sr_d    = b_pad << D;
                    g_sr_d    = g_pad << D;
                    dig_cnt_d = '0;
                    ctr_d     = 1'b1;
                    dv_d      = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = StStream;
                end
            end
            StStream: begin
                busy_d = 1'b1;
                if (dig_cnt_q == 4'(NDIG - 1)) begin
                    drain_d = 8'(FLUSH);
                    done_d  = (FLUSH == 1);
                    state_d = StFlush;
                end else begin
                    a_out_d   = a_sr_q[W-1 -: D];
                    b_out_d   = b_sr_q[W-1 -: D];
                    g_out_d   = g_sr_q[W-1 -: D];
                    a_sr_d    = a_sr_q << D;
                    b_sr_d    = b_sr_q << D;
                    g_sr_d    = g_sr_q << D;
                    dig_cnt_d = dig_cnt_q + 4'd1;
                    dv_d      = 1'b1;
                end
            end
            StFlush: begin
                // drain_q holds the number of drain cycles left, including the current one.
                if (drain_q == 8'd1) begin
                    drain_d = '0;
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q - 8'd1;
                    busy_d  = 1'b1;
                    done_d  = (drain_q == 8'd2);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, shift registers, counters and output flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            g_sr_q    <= '0;
            a_out_q   <= '0;
            b_out_q   <= '0;
            g_out_q   <= '0;
            ctr_q     <= 1'b0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dig_cnt_q <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            g_sr_q    <= g_sr_d;
            a_out_q   <= a_out_d;
            b_out_q   <= b_out_d;
            g_out_q   <= g_out_d;
            ctr_q     <= ctr_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dig_cnt_q <= dig_cnt_d;
            drain_q   <= drain_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.a_out     = a_out_q;
    assign bus.b_out     = b_out_q;
    assign bus.g_out     = g_out_q;
    assign bus.ctr_out   = ctr_q;
    assign bus.dig_valid = dv_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_sysmul_digit_feeder.sv
// Bench for sysmul_digit_feeder: timeline model checked every cycle plus directed literals.
module tb_sysmul_digit_feeder;
    localparam int M     = 163;
    localparam int D     = 16;
    localparam int NDIG  = 11;
    localparam int FLUSH = 22;
    localparam int W     = NDIG * D;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sysmul_digit_feeder_if #(.M(M), .D(D)) bus ();

    sysmul_digit_feeder #(.M(M), .D(D), .FLUSH(FLUSH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: an operation is described only by its acceptance cycle and captured operands.
    bit           act     = 1'b0;
    int           cyc     = 0;
    int           acc_cyc = 0;
    logic [W-1:0] pa, pb, pg;

    function automatic logic [15:0] dig(input logic [W-1:0] p, input int k);
        logic [W-1:0] s;
        s = p >> (D * (NDIG - 1 - k));
        return s[15:0];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act = 1'b0;
        end else begin
            if ((!act || (cyc - acc_cyc) > NDIG + FLUSH) && bus.in_valid) begin
                act     = 1'b1;
                acc_cyc = cyc;
                pa      = W'(bus.a_in);
                pb      = W'(bus.b_in);
                pg      = W'(bus.g_in);
            end
            cyc = cyc + 1;
        end
    end

    // Every-cycle comparison against the model timeline.
    always @(negedge clk) begin
        logic [15:0] ea, eb, eg;
        logic        ectr, edv, ebusy, edone, erdy;
        int          rel;
        if (rstn) begin
            rel = cyc - acc_cyc;
            ea = '0; eb = '0; eg = '0;
            ectr = 0; edv = 0; ebusy = 0; edone = 0; erdy = 1;
            if (act && rel >= 1 && rel <= NDIG) begin
                ea = dig(pa, rel - 1); eb = dig(pb, rel - 1); eg = dig(pg, rel - 1);
                ectr = (rel == 1); edv = 1; ebusy = 1; erdy = 0;
            end else if (act && rel >= 1 && rel <= NDIG + FLUSH) begin
                ebusy = 1; erdy = 0; edone = (rel == NDIG + FLUSH);
            end
            vectors++;
            if (bus.a_out !== ea || bus.b_out !== eb || bus.g_out !== eg ||
                bus.ctr_out !== ectr || bus.dig_valid !== edv || bus.busy !== ebusy ||
                bus.done !== edone || bus.in_ready !== erdy) begin
                miscompares++;
                $display("FAIL cycle %0d rel %0d: got a=%h b=%h g=%h ctr=%b dv=%b busy=%b done=%b rdy=%b, want a=%h b=%h g=%h ctr=%b dv=%b busy=%b done=%b rdy=%b",
                         cyc, rel, bus.a_out, bus.b_out, bus.g_out, bus.ctr_out, bus.dig_valid,
                         bus.busy, bus.done, bus.in_ready, ea, eb, eg, ectr, edv, ebusy, edone,
                         erdy);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic start_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic [M-1:0] g);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.g_in     = g;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [M-1:0] rand_op();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[M-1:0];
    endfunction

    initial begin
        logic [M-1:0] one, pat;
        int dv_cnt, busy_cnt, done_cnt, done_rel, ctr_cnt;
        logic rdy34;
        bus.in_valid = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.g_in = '0;
        one = 1;
        for (int i = 0; i < M; i += 2) pat[i] = 1'b1;
        for (int i = 1; i < M; i += 2) pat[i] = 1'b0;

        // Reset state.
        #1;
        check("reset_outputs", {bus.a_out, bus.b_out}, 32'd0);
        check("reset_flags", {28'd0, bus.ctr_out, bus.dig_valid, bus.busy, bus.done}, 32'd0);
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        tick();
        check("ready_after_reset", 32'(bus.in_ready), 32'd1);

        // Single 1 in the LSB of A; G = x^7+x^6+x^3+1.
        start_op(one, '0, M'('hC9));
        check("single_ctr_t1", 32'(bus.ctr_out), 32'd1);
        check("single_a_d0", 32'(bus.a_out), 32'd0);
        repeat (10) tick();
        check("single_a_d10", 32'(bus.a_out), 32'h0001);
        check("single_g_d10", 32'(bus.g_out), 32'h00C9);
        tick();
        check("single_dv_after", 32'(bus.dig_valid), 32'd0);

        // Top bit of A, all ones in B.
        wait_idle();
        start_op(one << 162, '1, '0);
        check("top_a_d0", 32'(bus.a_out), 32'h0004);
        check("top_b_d0", 32'(bus.b_out), 32'h0007);
        tick();
        check("top_a_d1", 32'(bus.a_out), 32'h0000);
        check("top_b_d1", 32'(bus.b_out), 32'hFFFF);

        // Timing of a full operation.
        wait_idle();
        start_op(rand_op(), rand_op(), rand_op());
        dv_cnt = 0; busy_cnt = 0; done_cnt = 0; done_rel = 0; rdy34 = 1'b0;
        for (int r = 1; r <= 40; r++) begin
            if (bus.dig_valid) dv_cnt++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_rel = r;
            end
            if (r == 34) rdy34 = bus.in_ready;
            tick();
        end
        check("timing_dv_cycles", 32'(dv_cnt), 32'd11);
        check("timing_busy_cycles", 32'(busy_cnt), 32'd33);
        check("timing_done_count", 32'(done_cnt), 32'd1);
        check("timing_done_cycle", 32'(done_rel), 32'd33);
        check("timing_ready_t34", 32'(rdy34), 32'd1);

        // Alternating-bit pattern.
        wait_idle();
        start_op(pat, pat, pat);
        check("pattern_a_d0", 32'(bus.a_out), 32'h0005);
        tick();
        check("pattern_a_d1", 32'(bus.a_out), 32'h5555);

        // in_valid held high with operands changing while busy.
        wait_idle();
        bus.a_in = rand_op(); bus.b_in = rand_op(); bus.g_in = rand_op();
        bus.in_valid = 1'b1;
        tick();
        ctr_cnt = 0;
        for (int i = 1; i <= 33; i++) begin
            if (bus.ctr_out) ctr_cnt++;
            bus.a_in = rand_op(); bus.b_in = rand_op(); bus.g_in = rand_op();
            tick();
        end
        check("hold_ctr_during_op", 32'(ctr_cnt), 32'd1);
        bus.a_in = M'('h1234);
        tick();
        check("hold_second_accept", 32'(bus.ctr_out), 32'd1);
        bus.in_valid = 1'b0;
        bus.a_in = rand_op();
        repeat (10) tick();
        check("hold_second_a_d10", 32'(bus.a_out), 32'h1234);

        // Reset in the middle of the stream at digit 5.
        wait_idle();
        start_op(rand_op(), rand_op(), rand_op());
        repeat (5) tick();
        check("mid_dv_d5", 32'(bus.dig_valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("mid_reset_data", {bus.a_out, bus.b_out}, 32'd0);
        check("mid_reset_flags", {15'd0, bus.g_out, bus.ctr_out, bus.dig_valid, bus.busy,
                                  bus.done}, 32'd0);
        @(posedge clk);
        #3 rstn = 1'b1;
        check("mid_ready_release", 32'(bus.in_ready), 32'd1);
        done_cnt = 0; dv_cnt = 0;
        for (int r = 0; r < 40; r++) begin
            tick();
            if (bus.done) done_cnt++;
            if (bus.dig_valid) dv_cnt++;
        end
        check("mid_no_done", 32'(done_cnt), 32'd0);
        check("mid_no_digits", 32'(dv_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
